// File: rtl/xillyvga_fb_fetch_if.sv
// AXI4 read-address and read-data channel bundle used by the framebuffer
// fetch scheduler to reach system memory.
//   master modport: issues AR requests and accepts R beats (the fetch engine)
//   slave  modport: memory side / interconnect
// Signals follow AXI4 naming without the m_axi_ prefix:
//   araddr/arlen/arvalid/arready/arburst/arsize/arcache/arprot  address channel
//   rdata/rvalid/rlast/rresp/rready                              data channel
interface xillyvga_fb_fetch_if;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [1:0]  arburst;
  logic [2:0]  arsize;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rlast;
  logic [1:0]  rresp;
  logic        rready;

  modport master (
    output araddr, arlen, arvalid, arburst, arsize, arcache, arprot, rready,
    input  arready, rdata, rvalid, rlast, rresp
  );

  modport slave (
    input  araddr, arlen, arvalid, arburst, arsize, arcache, arprot, rready,
    output arready, rdata, rvalid, rlast, rresp
  );
endinterface

// File: rtl/xillyvga_fb_fetch.sv
// Framebuffer fetch scheduler for the VGA/DVI output path.
// Once per frame it walks a linear framebuffer with INCR read bursts and
// streams the returned 32-bit pixel words straight into the pixel FIFO.
// A burst is only requested when the FIFO can absorb all of its beats, so
// the R channel is never back-pressured.
// Ports:
//   m_axi_aclk / m_axi_aresetn  clock, async active-low reset
//   enable                      fetch enable level
//   frame_start                 1-cycle pulse at start of vertical blank
//   fb_base, frame_words        frame base byte address (64 B aligned), word count
//   fifo_free                   free word slots in the pixel FIFO
//   fifo_wr, fifo_wdata         pixel FIFO write port
//   m_axi                       AXI4 read channels (master)
//   busy                        frame fetch in progress
//   overrun, rd_err             sticky status, cleared by clr_flags
module xillyvga_fb_fetch #(
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 20,
  parameter int FREE_W    = 10
) (
  input  logic                 m_axi_aclk,
  input  logic                 m_axi_aresetn,
  input  logic                 enable,
  input  logic                 frame_start,
  input  logic [31:0]          fb_base,
  input  logic [CNT_W-1:0]     frame_words,
  input  logic [FREE_W-1:0]    fifo_free,
  output logic                 fifo_wr,
  output logic [31:0]          fifo_wdata,
  xillyvga_fb_fetch_if.master  m_axi,
  output logic                 busy,
  output logic                 overrun,
  output logic                 rd_err,
  input  logic                 clr_flags
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_AR, S_DATA} state_t;

  localparam logic [4:0] BL = 5'(BURST_LEN);

  state_t           state;
  logic [31:0]      addr;
  logic [CNT_W-1:0] remain;
  logic [4:0]       cur_beats;
  // A frame_start that lands while a burst is in flight is parked here and
  // applied once that burst's rlast has been taken.
  logic             pend;
  logic [31:0]      pend_base;
  logic [CNT_W-1:0] pend_words;
  logic [31:0]      araddr_q;
  logic [3:0]       arlen_q;
  logic             arvalid_q;
  logic             rready_q;

  logic [31:0]      base_aligned;
  logic [4:0]       beats;
  logic             start_ok;
  logic             beat;

  assign base_aligned = fb_base & 32'hFFFF_FFC0;
  assign start_ok     = frame_start & enable & (frame_words != '0);
  assign beat         = rready_q & m_axi.rvalid;

  // Last burst of a frame is shortened to whatever is left.
  always_comb begin
    beats = BL;
    if (remain < CNT_W'(BURST_LEN)) beats = remain[4:0];
  end

  assign fifo_wr         = beat;
  assign fifo_wdata      = m_axi.rdata;
  assign m_axi.araddr    = araddr_q;
  assign m_axi.arlen     = arlen_q;
  assign m_axi.arvalid   = arvalid_q;
  assign m_axi.rready    = rready_q;
  assign m_axi.arburst   = 2'b01;
  assign m_axi.arsize    = 3'b010;
  assign m_axi.arcache   = 4'b0011;
  assign m_axi.arprot    = 3'b000;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state      <= S_IDLE;
      addr       <= '0;
      remain     <= '0;
      cur_beats  <= '0;
      pend       <= 1'b0;
      pend_base  <= '0;
      pend_words <= '0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      // Set has priority over clear for both sticky flags.
      if (start_ok && busy)                   overrun <= 1'b1;
      else if (clr_flags)                     overrun <= 1'b0;
      if (beat && (m_axi.rresp != 2'b00))     rd_err  <= 1'b1;
      else if (clr_flags)                     rd_err  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start_ok) begin
            addr   <= base_aligned;
            remain <= frame_words;
            busy   <= 1'b1;
            state  <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (!enable) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (start_ok) begin
            // No burst in flight: restart the frame immediately.
            addr   <= base_aligned;
            remain <= frame_words;
          end else if (fifo_free >= FREE_W'(beats)) begin
            araddr_q  <= addr;
            arlen_q   <= 4'(beats - 5'd1);
            cur_beats <= beats;
            arvalid_q <= 1'b1;
            state     <= S_AR;
          end
        end

        S_AR: begin
          if (start_ok) begin
            pend       <= 1'b1;
            pend_base  <= base_aligned;
            pend_words <= frame_words;
          end
          if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            addr      <= addr + {25'd0, cur_beats, 2'b00};
            remain    <= remain - CNT_W'(cur_beats);
            state     <= S_DATA;
          end
        end

        S_DATA: begin
          if (start_ok) begin
            pend       <= 1'b1;
            pend_base  <= base_aligned;
            pend_words <= frame_words;
          end
          if (beat && m_axi.rlast) begin
            rready_q <= 1'b0;
            pend     <= 1'b0;
            if (!enable) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else if (start_ok) begin
              addr   <= base_aligned;
              remain <= frame_words;
              state  <= S_WAIT;
            end else if (pend) begin
              addr   <= pend_base;
              remain <= pend_words;
              state  <= S_WAIT;
            end else if (remain == '0) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              state <= S_WAIT;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
